// File: rtl/md_audio_mixer.sv
// md_audio_mixer: NCH-channel stereo mixer with volume, pan and saturation.
// Optional DC blocker after saturation: define MIXER_DC_BLOCK_EN.
module md_audio_mixer #(
  parameter int NCH  = 4,
  parameter int IW   = 16,
  parameter int OW   = 16,
  parameter int VOLW = 4,
  parameter int DCK  = 8
) (
  input  logic               MCLK,
  input  logic               SRES,
  input  logic               SMP_STB,
  input  logic [NCH*IW-1:0]  CH_IN,
  input  logic [NCH*VOLW-1:0] CH_VOL,
  input  logic [NCH*2-1:0]   CH_PAN,
  input  logic               OVR_CLR,
  output logic [OW-1:0]      MOL,
  output logic [OW-1:0]      MOR,
  output logic               OUT_VALID,
  output logic               BUSY,
  output logic               CLIP,
  output logic               OVERRUN
);

  localparam int PW = IW + VOLW + 1;
  localparam int CL = $clog2(NCH);
  localparam int AW = PW + CL;
  localparam int SH = VOLW - 1 + IW - OW;
  localparam int KW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [KW-1:0]          k;
  logic signed [IW-1:0]   ch_q  [NCH];
  logic [VOLW-1:0]        vol_q [NCH];
  logic [1:0]             pan_q [NCH];
  logic signed [AW-1:0]   acc_l, acc_r;
  logic signed [AW-1:0]   sum_l, sum_r;
  logic signed [AW-1:0]   shr_l, shr_r;
  logic signed [PW-1:0]   ch_x, vol_x, prod;
  logic signed [AW-1:0]   p_ext;
  logic [OW:0]            res_l, res_r;
  logic                   accept, last;

  // Clamp a wide accumulator to OW bits; MSB of result flags clipping.
  function automatic logic [OW:0] sat_acc(
    input logic signed [AW-1:0] v
  );
    logic [OW:0] r;
    if (v[AW-1:OW-1] == '0 || v[AW-1:OW-1] == '1)
      r = {1'b0, v[OW-1:0]};
    else if (v[AW-1])
      r = {2'b11, {(OW-1){1'b0}}};
    else
      r = {2'b10, {(OW-1){1'b1}}};
    return r;
  endfunction

  assign accept = SMP_STB && (state == IDLE || state == DONE);
  assign last   = (state == ACC) && (k == KLAST);
  assign BUSY   = (state == ACC);

  // State register.
  always_ff @(posedge MCLK) begin
    if (SRES) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state logic: strobes are taken in IDLE and DONE only.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = ACC;
      ACC:     if (last) state_nx = DONE;
      DONE:    state_nx = accept ? ACC : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Latch the channel inputs at the start of a mix.
  always_ff @(posedge MCLK) begin
    if (SRES) begin
      for (int i = 0; i < NCH; i++) begin
        ch_q[i]  <= '0;
        vol_q[i] <= '0;
        pan_q[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < NCH; i++) begin
        ch_q[i]  <= CH_IN[i*IW +: IW];
        vol_q[i] <= CH_VOL[i*VOLW +: VOLW];
        pan_q[i] <= CH_PAN[i*2 +: 2];
      end
    end
  end

  // Channel index walks 0..NCH-1 during ACC.
  always_ff @(posedge MCLK) begin
    if (SRES)             k <= '0;
    else if (accept)      k <= '0;
    else if (state == ACC) k <= k + KW'(1);
  end

  // Product of the current channel and the running sums including it.
  always_comb begin
    ch_x  = PW'(ch_q[k]);
    vol_x = PW'({1'b0, vol_q[k]});
    prod  = ch_x * vol_x;
    p_ext = AW'(prod);
    sum_l = acc_l + (pan_q[k][1] ? p_ext : '0);
    sum_r = acc_r + (pan_q[k][0] ? p_ext : '0);
    shr_l = sum_l >>> SH;
    shr_r = sum_r >>> SH;
    res_l = sat_acc(shr_l);
    res_r = sat_acc(shr_r);
  end

  // Accumulators clear on acceptance and add one channel per ACC cycle.
  always_ff @(posedge MCLK) begin
    if (SRES || accept) begin
      acc_l <= '0;
      acc_r <= '0;
    end else if (state == ACC) begin
      acc_l <= sum_l;
      acc_r <= sum_r;
    end
  end

  // Sticky overrun; a new overrun strobe beats a clear.
  always_ff @(posedge MCLK) begin
    if (SRES)
      OVERRUN <= 1'b0;
    else if (SMP_STB && state == ACC)
      OVERRUN <= 1'b1;
    else if (OVR_CLR)
      OVERRUN <= 1'b0;
  end

`ifdef MIXER_DC_BLOCK_EN

  localparam int BW = OW + 2;

  logic signed [OW-1:0] x_l, x_r;
  logic signed [OW-1:0] xp_l, xp_r;
  logic signed [OW-1:0] yp_l, yp_r;
  logic                 clip_q, mid_valid;
  logic [OW:0]          y_l, y_r;

  // y = sat(x - xp + yp - (yp >>> DCK)); MSB flags clipping.
  function automatic logic [OW:0] dc_blk(
    input logic signed [OW-1:0] x,
    input logic signed [OW-1:0] xp,
    input logic signed [OW-1:0] yp
  );
    logic signed [BW-1:0] s;
    logic [OW:0] r;
    s = BW'(x) - BW'(xp) + BW'(yp) - (BW'(yp) >>> DCK);
    if (s[BW-1:OW-1] == '0 || s[BW-1:OW-1] == '1)
      r = {1'b0, s[OW-1:0]};
    else if (s[BW-1])
      r = {2'b11, {(OW-1){1'b0}}};
    else
      r = {2'b10, {(OW-1){1'b1}}};
    return r;
  endfunction

  // Blocker outputs from the staged saturated samples.
  always_comb begin
    y_l = dc_blk(x_l, xp_l, yp_l);
    y_r = dc_blk(x_r, xp_r, yp_r);
  end

  // Stage the saturated mix as the blocker input.
  always_ff @(posedge MCLK) begin
    if (SRES) begin
      x_l       <= '0;
      x_r       <= '0;
      clip_q    <= 1'b0;
      mid_valid <= 1'b0;
    end else begin
      mid_valid <= last;
      if (last) begin
        x_l    <= res_l[OW-1:0];
        x_r    <= res_r[OW-1:0];
        clip_q <= res_l[OW] | res_r[OW];
      end
    end
  end

  // Blocker state and registered outputs.
  always_ff @(posedge MCLK) begin
    if (SRES) begin
      xp_l      <= '0;
      xp_r      <= '0;
      yp_l      <= '0;
      yp_r      <= '0;
      MOL       <= '0;
      MOR       <= '0;
      OUT_VALID <= 1'b0;
      CLIP      <= 1'b0;
    end else begin
      OUT_VALID <= mid_valid;
      CLIP      <= mid_valid &
                   (clip_q | y_l[OW] | y_r[OW]);
      if (mid_valid) begin
        xp_l <= x_l;
        xp_r <= x_r;
        yp_l <= y_l[OW-1:0];
        yp_r <= y_r[OW-1:0];
        MOL  <= y_l[OW-1:0];
        MOR  <= y_r[OW-1:0];
      end
    end
  end

`else

  logic unused_dck;
  assign unused_dck = ^DCK;

  // Registered outputs load as the mix leaves ACC.
  always_ff @(posedge MCLK) begin
    if (SRES) begin
      MOL       <= '0;
      MOR       <= '0;
      OUT_VALID <= 1'b0;
      CLIP      <= 1'b0;
    end else begin
      OUT_VALID <= last;
      CLIP      <= last & (res_l[OW] | res_r[OW]);
      if (last) begin
        MOL <= res_l[OW-1:0];
        MOR <= res_r[OW-1:0];
      end
    end
  end

`endif

endmodule

// File: tb/tb_md_audio_mixer.sv
// tb_md_audio_mixer: directed table vectors plus overrun, reset and
// back-to-back sequences for md_audio_mixer (NCH=4, IW=OW=16, VOLW=4).
module tb_md_audio_mixer;

`ifdef MIXER_DC_BLOCK_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic        clk = 1'b0;
  logic        sres, stb, ovr_clr;
  logic [63:0] ch_in;
  logic [15:0] ch_vol;
  logic [7:0]  ch_pan;
  logic [15:0] mol, mor;
  logic        out_valid, busy, clip, overrun;

  int total = 0;
  int pass  = 0;

  always #5 clk = ~clk;

  md_audio_mixer #(
    .NCH(4), .IW(16), .OW(16), .VOLW(4), .DCK(8)
  ) dut (
    .MCLK(clk),
    .SRES(sres),
    .SMP_STB(stb),
    .CH_IN(ch_in),
    .CH_VOL(ch_vol),
    .CH_PAN(ch_pan),
    .OVR_CLR(ovr_clr),
    .MOL(mol),
    .MOR(mor),
    .OUT_VALID(out_valid),
    .BUSY(busy),
    .CLIP(clip),
    .OVERRUN(overrun)
  );

  typedef struct {
    string       name;
    logic [63:0] ch;
    logic [15:0] vol;
    logic [7:0]  pan;
    logic [15:0] el;
    logic [15:0] er;
    logic        ec;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(
    input string nm, input logic [63:0] c,
    input logic [15:0] v, input logic [7:0] p,
    input logic [15:0] l, input logic [15:0] r,
    input logic cl
  );
    vec_t t;
    t.name = nm; t.ch = c; t.vol = v; t.pan = p;
    t.el = l; t.er = r; t.ec = cl;
    return t;
  endfunction

  task automatic chk(
    input string nm, input logic [31:0] act,
    input logic [31:0] exp
  );
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h",
                  nm, act, exp);
  endtask

  // Drive one vector with a one-cycle strobe; return cycles to OUT_VALID.
  task automatic run_mix(input vec_t v, output int n);
    ch_in  = v.ch;
    ch_vol = v.vol;
    ch_pan = v.pan;
    stb    = 1'b1;
    n      = 0;
    @(posedge clk); #1;
    stb = 1'b0;
    n   = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic count_pulses(input int cyc, output int p);
    p = 0;
    for (int i = 0; i < cyc; i++) begin
      @(posedge clk); #1;
      if (out_valid) p++;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    int lat;
    int np;

    tbl[0]  = mk("unity",  64'h0000_0000_0000_1000,
                 16'h0008, 8'h03, 16'h1000, 16'h1000, 1'b0);
    tbl[1]  = mk("pos_sat", 64'h7000_7000_7000_7000,
                 16'hFFFF, 8'hAA, 16'h7FFF, 16'h0000, 1'b1);
    tbl[2]  = mk("neg_sat", 64'h8000_8000_8000_8000,
                 16'hFFFF, 8'hAA, 16'h8000, 16'h0000, 1'b1);
    tbl[3]  = mk("pan_mix", 64'h0000_0000_FF00_0100,
                 16'h0088, 8'h07, 16'h0100, 16'h0000, 1'b0);
    tbl[4]  = mk("right",  64'h0400_0400_0400_0400,
                 16'h8888, 8'h55, 16'h0000, 16'h1000, 1'b0);
    tbl[5]  = mk("min_ex", 64'h0000_0000_0000_8000,
                 16'h0008, 8'h03, 16'h8000, 16'h8000, 1'b0);
    tbl[6]  = mk("max_ex", 64'h0000_0000_0000_7FFF,
                 16'h0008, 8'h03, 16'h7FFF, 16'h7FFF, 1'b0);
    tbl[7]  = mk("mixed",  64'h1234_0010_F000_2000,
                 16'h0FC4, 8'hDE, 16'hF800, 16'hE81E, 1'b0);
    tbl[8]  = mk("mute",   64'h7FFF_7FFF_7FFF_7FFF,
                 16'h8800, 8'h0F, 16'h0000, 16'h0000, 1'b0);
    tbl[9]  = mk("neg_one", 64'h0000_0000_0000_FFFF,
                 16'h0001, 8'h03, 16'hFFFF, 16'hFFFF, 1'b0);
    tbl[10] = mk("one_clip", 64'h0000_0000_0000_7FFF,
                 16'h000F, 8'h02, 16'h7FFF, 16'h0000, 1'b1);

    // Reset with a strobe held high: reset must win.
    sres    = 1'b1;
    stb     = 1'b1;
    ovr_clr = 1'b0;
    ch_in   = tbl[1].ch;
    ch_vol  = tbl[1].vol;
    ch_pan  = tbl[1].pan;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mol", 32'(mol), 32'h0);
    chk("rst_mor", 32'(mor), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_clip", 32'(clip), 32'h0);
    chk("rst_ovr", 32'(overrun), 32'h0);
    sres = 1'b0;
    stb  = 1'b0;
    @(posedge clk); #1;

`ifndef MIXER_DC_BLOCK_EN
    // Table vectors: latency, outputs, clip, busy, then hold.
    for (int i = 0; i < 11; i++) begin
      run_mix(tbl[i], lat);
      chk({tbl[i].name, "_lat"}, 32'(lat), 32'(LAT));
      chk({tbl[i].name, "_mol"}, 32'(mol), 32'(tbl[i].el));
      chk({tbl[i].name, "_mor"}, 32'(mor), 32'(tbl[i].er));
      chk({tbl[i].name, "_clip"}, 32'(clip), 32'(tbl[i].ec));
      chk({tbl[i].name, "_busy"}, 32'(busy), 32'h0);
      @(posedge clk); #1;
      chk({tbl[i].name, "_vpulse"}, 32'(out_valid), 32'h0);
      chk({tbl[i].name, "_hold"}, 32'(mol), 32'(tbl[i].el));
      chk({tbl[i].name, "_clpulse"}, 32'(clip), 32'h0);
    end

    // Back-to-back: second strobe lands in the DONE cycle.
    run_mix(tbl[0], lat);
    chk("b2b_a_lat", 32'(lat), 32'(LAT));
    run_mix(tbl[4], lat);
    chk("b2b_b_lat", 32'(lat), 32'(LAT));
    chk("b2b_b_mol", 32'(mol), 32'h0000);
    chk("b2b_b_mor", 32'(mor), 32'h1000);
    chk("b2b_ovr", 32'(overrun), 32'h0);

    // Overrun: second strobe two cycles into the mix is ignored.
    @(posedge clk); #1;
    ch_in  = tbl[0].ch;
    ch_vol = tbl[0].vol;
    ch_pan = tbl[0].pan;
    stb    = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    @(posedge clk); #1;
    ch_in  = tbl[1].ch;
    ch_vol = tbl[1].vol;
    ch_pan = tbl[1].pan;
    stb    = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    chk("ovr_set", 32'(overrun), 32'h1);
    chk("ovr_busy", 32'(busy), 32'h1);
    wait_valid(lat);
    chk("ovr_lat", 32'(lat + 3), 32'(LAT));
    chk("ovr_mol", 32'(mol), 32'h1000);
    chk("ovr_mor", 32'(mor), 32'h1000);
    count_pulses(10, np);
    chk("ovr_pulses", 32'(np), 32'h0);
    chk("ovr_sticky", 32'(overrun), 32'h1);
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    chk("ovr_clr", 32'(overrun), 32'h0);

    // Clear and overrun strobe in the same cycle: stays set.
    ch_in  = tbl[0].ch;
    ch_vol = tbl[0].vol;
    ch_pan = tbl[0].pan;
    stb    = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    stb     = 1'b0;
    ovr_clr = 1'b0;
    chk("ovr_clr_tie", 32'(overrun), 32'h1);
    wait_valid(lat);
    chk("ovr_tie_done", 32'(out_valid), 32'h1);
    ovr_clr = 1'b1;
    @(posedge clk); #1;
    ovr_clr = 1'b0;
    chk("ovr_clr2", 32'(overrun), 32'h0);

    // Reset in the third ACC cycle aborts the mix.
    ch_in  = tbl[1].ch;
    ch_vol = tbl[1].vol;
    ch_pan = tbl[1].pan;
    stb    = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sres = 1'b1;
    @(posedge clk); #1;
    sres = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_mol", 32'(mol), 32'h0);
    chk("abort_mor", 32'(mor), 32'h0);
    chk("abort_valid", 32'(out_valid), 32'h0);
    count_pulses(10, np);
    chk("abort_pulses", 32'(np), 32'h0);
    run_mix(tbl[3], lat);
    chk("post_lat", 32'(lat), 32'(LAT));
    chk("post_mol", 32'(mol), 32'h0100);
    chk("post_mor", 32'(mor), 32'h0000);
`else
    // Constant 0x1000 mix through the DC blocker decays from 0x1000.
    run_mix(tbl[0], lat);
    chk("dc0_lat", 32'(lat), 32'(LAT));
    chk("dc0_mol", 32'(mol), 32'h1000);
    chk("dc0_mor", 32'(mor), 32'h1000);
    @(posedge clk); #1;
    run_mix(tbl[0], lat);
    chk("dc1_lat", 32'(lat), 32'(LAT));
    chk("dc1_mol", 32'(mol), 32'h0FF0);
    chk("dc1_mor", 32'(mor), 32'h0FF0);
    @(posedge clk); #1;
    run_mix(tbl[0], lat);
    chk("dc2_mol", 32'(mol), 32'h0FE1);
    chk("dc2_mor", 32'(mor), 32'h0FE1);
    chk("dc2_clip", 32'(clip), 32'h0);
    @(posedge clk); #1;
    chk("dc2_vpulse", 32'(out_valid), 32'h0);
    chk("dc2_hold", 32'(mol), 32'h0FE1);
    chk("dc_ovr", 32'(overrun), 32'h0);
`endif

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
